ex_stage: RTL

Parametrised execute stage of the DLX pipeline, sitting between ID and MEM. It selects ALU operands with multi-source forwarding that never forwards register 0. It resolves conditional branches and detects load-use hazards, stalling upstream for one cycle. An optional iterative multiplier stalls the pipe until its result is ready. Outputs are registered into the EX/MEM pipeline register with a valid bit, so bubbles are explicit.

---
 rtl/dlx_ex_pkg.sv | 14 +
 rtl/ex_mul_iter.sv | 52 +++++
 rtl/ex_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/dlx_ex_pkg.sv
// dlx_ex_pkg: ALU operation encodings and multiplier state type for the DLX execute stage
package dlx_ex_pkg;
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_XOR = 5'd4;
  localparam logic [4:0] ALU_SLL = 5'd5;
  localparam logic [4:0] ALU_SRL = 5'd6;
  localparam logic [4:0] ALU_SRA = 5'd7;
  localparam logic [4:0] ALU_SLT = 5'd8;
  localparam logic [4:0] ALU_SEQ = 5'd9;
  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;
endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: iterative shift-add multiplier, one partial product per cycle, low XLEN bits kept
module ex_mul_iter
  import dlx_ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);
  localparam int CW = $clog2(XLEN + 1);
  mul_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] mcand, mplier, acc;
  // state register
  always_ff @(posedge clk) state <= !reset_n ? MUL_IDLE : state_nx;
  // next state; flush returns to IDLE from any state
  always_comb begin
    state_nx = state;
    if (flush) state_nx = MUL_IDLE;
    else if (state == MUL_IDLE) state_nx = start ? MUL_BUSY : MUL_IDLE;
    else if (state == MUL_BUSY) state_nx = cnt == CW'(1) ? MUL_DONE : MUL_BUSY;
    else state_nx = MUL_IDLE;
  end
  // latch operands on accept, then add the shifted multiplicand for each set multiplier bit
  always_ff @(posedge clk)
    if (!reset_n) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (state == MUL_IDLE && start && !flush) begin
      cnt    <= CW'(XLEN);
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (state == MUL_BUSY) begin
      acc    <= acc + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  assign busy    = state == MUL_BUSY;
  assign done    = state == MUL_DONE;
  assign product = acc;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: DLX execute stage with forwarding, branch resolve, load-use stall; EX_MUL_EN adds an iterative multiplier
module ex_stage
  import dlx_ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      valid_EX,
  input  logic                      flush_EX,
  input  logic                      Pc_cmd_ex_EX,
  input  logic                      d_write_enable_EX,
  input  logic                      d_load_enable_EX,
  input  logic                      Iv_alu_EX,
  input  logic                      Pc_alu_EX,
  input  logic                      mul_EX,
  input  logic [4:0]                I_EX,
  input  logic [REG_AW-1:0]         Rd_EX,
  input  logic [REG_AW-1:0]         Rs1_EX,
  input  logic [REG_AW-1:0]         Rs2_EX,
  input  logic [XLEN-1:0]           Iv_EX,
  input  logic [XLEN-1:0]           S1_EX,
  input  logic [XLEN-1:0]           S2_EX,
  input  logic [XLEN-1:0]           PC_EX,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  output logic                      stall_EX,
  output logic                      pc_cmd_EX,
  output logic [XLEN-1:0]           pc_in_EX,
  output logic [XLEN-1:0]           ALU_out_MEM,
  output logic [XLEN-1:0]           S2_MEM,
  output logic [REG_AW-1:0]         Rd_MEM,
  output logic                      d_write_enable_MEM,
  output logic                      d_load_enable_MEM,
  output logic                      valid_MEM
);
  localparam int SW = $clog2(XLEN);
  logic [XLEN-1:0] reg1, reg2, op1, op2, alu_res, ex_result;
  logic load_use, mul_stall, bubble;
  // forwarding: scan oldest to youngest so the youngest matching source wins; r0 is never forwarded
  always_comb begin
    reg1 = S1_EX;
    reg2 = S2_EX;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && Rs1_EX != '0 && fwd_rd[i*REG_AW +: REG_AW] == Rs1_EX) reg1 = fwd_data[i*XLEN +: XLEN];
      if (fwd_valid[i] && Rs2_EX != '0 && fwd_rd[i*REG_AW +: REG_AW] == Rs2_EX) reg2 = fwd_data[i*XLEN +: XLEN];
    end
  end
  assign op1 = Pc_alu_EX ? PC_EX : reg1;
  assign op2 = Iv_alu_EX ? Iv_EX : reg2;
  // ALU
  always_comb begin
    alu_res = '0;
    case (I_EX)
      ALU_ADD: alu_res = op1 + op2;
      ALU_SUB: alu_res = op1 - op2;
      ALU_AND: alu_res = op1 & op2;
      ALU_OR:  alu_res = op1 | op2;
      ALU_XOR: alu_res = op1 ^ op2;
      ALU_SLL: alu_res = op1 << op2[SW-1:0];
      ALU_SRL: alu_res = op1 >> op2[SW-1:0];
      ALU_SRA: alu_res = $signed(op1) >>> op2[SW-1:0];
      ALU_SLT: alu_res = XLEN'($signed(op1) < $signed(op2));
      ALU_SEQ: alu_res = XLEN'(op1 == op2);
      default: alu_res = '0;
    endcase
  end
  assign load_use = valid_EX & valid_MEM & d_load_enable_MEM & (Rd_MEM != '0) &
                    (Rd_MEM == Rs1_EX | Rd_MEM == Rs2_EX);
`ifdef EX_MUL_EN
  logic mul_start, mul_busy, mul_done;
  logic [XLEN-1:0] mul_product;
  assign mul_start = valid_EX & mul_EX & !flush_EX & !load_use;
  ex_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .flush   (flush_EX),
    .a       (op1),
    .b       (op2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
  assign mul_stall = mul_busy | (mul_start & !mul_done);
  assign ex_result = (mul_EX & mul_done) ? mul_product : alu_res;
`else
  logic unused_mul;
  assign unused_mul = mul_EX;
  assign mul_stall  = 1'b0;
  assign ex_result  = alu_res;
`endif
  assign stall_EX  = load_use | mul_stall;
  assign pc_cmd_EX = valid_EX & Pc_cmd_ex_EX & (alu_res == '0) & !stall_EX & !flush_EX;
  assign pc_in_EX  = pc_cmd_EX ? PC_EX + Iv_EX : '0;
  assign bubble    = stall_EX | flush_EX | !valid_EX;
  // EX/MEM pipeline register; stalls and flushes become explicit bubbles
  always_ff @(posedge clk)
    if (!reset_n) begin
      ALU_out_MEM        <= '0;
      S2_MEM             <= '0;
      Rd_MEM             <= '0;
      d_write_enable_MEM <= 1'b0;
      d_load_enable_MEM  <= 1'b0;
      valid_MEM          <= 1'b0;
    end else begin
      ALU_out_MEM        <= ex_result;
      S2_MEM             <= reg2;
      Rd_MEM             <= bubble ? '0 : Rd_EX;
      d_write_enable_MEM <= !bubble & d_write_enable_EX;
      d_load_enable_MEM  <= !bubble & d_load_enable_EX;
      valid_MEM          <= !bubble;
    end
endmodule
